avalon_lsu_master: RTL
======================

// Module: avalon_lsu_master
// PURPOSE
//  Avalon-MM master that services the RISC-V core's load/store unit against Avalon-MM data slaves
//  (on-chip RAM, peripherals). Takes one byte/half/word request at a time and generates byteenables
//  and write-lane replication. Handles waitrequest stalls and fixed read latency. Returns
//  sign/zero-extended load data. Misaligned accesses are rejected without touching the bus.
// PARAMETERS
//  ADDR_W        12  byte-address width of req_addr; avm_address = req_addr[ADDR_W-1:2]
//  READ_LATENCY   1  slave fixed read latency in cycles, legal range 1..4 (on-chip RAM = 1)
// PORTS
//  clk              in   1         system clock
//  reset            in   1         synchronous, active-high reset
//  req_valid        in   1         core request valid
//  req_ready        out  1         block can accept a request (IDLE only)
//  req_we           in   1         1 = store, 0 = load
//  req_addr         in   ADDR_W    byte address
//  req_size         in   2         00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned     in   1         load zero-extend (1) / sign-extend (0)
//  req_wdata        in   32        store data, right-justified
//  rsp_valid        out  1         one-cycle response pulse
//  rsp_rdata        out  32        extended load data (0 for stores/errors), held until next rsp
//  rsp_err          out  1         misaligned or illegal size, qualified by rsp_valid
//  avm_address      out  ADDR_W-2  word address
//  avm_byteenable   out  4         lane enables
//  avm_chipselect   out  1         asserted with avm_read or avm_write
//  avm_read         out  1         read strobe
//  avm_write        out  1         write strobe
//  avm_writedata    out  32        lane-replicated store data
//  avm_readdata     in   32        slave read data
//  avm_waitrequest  in   1         slave stall; command held stable while high
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high on reset.
//  - Reset, all at the next clk edge: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0;
//    rsp_rdata=0; avm_read=0; avm_write=0; avm_chipselect=0; avm_address=0; avm_byteenable=0;
//    avm_writedata=0. Reset mid-transfer aborts it, discards pending read data, and issues no response.
//  - FSM states: IDLE, CMD, RDWAIT, RESP.
//    * IDLE: req_ready=1. On req_valid, latch the request.
//      Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with err=1, no bus cycle.
//      Otherwise -> CMD.
//    * CMD: avm_read or avm_write, plus chipselect, are asserted. Address, byteenable and writedata stay stable.
//      Leave CMD on the first cycle with waitrequest=0: a write -> RESP, a read -> RDWAIT (load counter=READ_LATENCY-1).
//    * RDWAIT: strobes deasserted. Counter decrements each cycle.
//      When counter==0 and cycle count from accept = READ_LATENCY, sample avm_readdata -> RESP.
//    * RESP: rsp_valid=1 for exactly one cycle -> IDLE. req_ready=0 during RESP.
//  - Timing: request accepted at edge T. The command is visible in cycle T+1.
//    With waitrequest low in that cycle: write rsp_valid in cycle T+2; read rsp_valid in cycle T+2+READ_LATENCY.
//    Each waitrequest-high cycle adds one cycle.
//  - Byteenable: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
//  - Writedata: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
//  - Load extract: the lane is selected by a[1:0]. Sign-extend from bit 7/15 unless req_unsigned. Word passes through.
//  - Only one request is outstanding. req_valid is ignored outside IDLE. A request arriving in the same cycle as reset is dropped.
// STRUCTURE
//  - Package avalon_lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, READ_LATENCY bounds.
//  - Sub-module avalon_lsu_align (combinational): byteenable, write-lane replication, load extract/extend, misalign flag.
//  - Top: FSM, request latch, latency counter, response registers.
// TESTING
//  - Reset: assert reset for 2 cycles mid-read -> all outputs at reset values, no rsp_valid, req_ready=1.
//  - SB 0xA5 to addr 0x006 -> avm_address=0x001, be=4'b0100, writedata=0xA5A5A5A5; rsp_valid 2 cycles after accept, err=0.
//  - LH signed at 0x00A, memory word 0x80F1_0000 -> be=4'b1100, rsp_rdata=0xFFFF80F1; unsigned -> 0x000080F1.
//  - LW at 0x010 with waitrequest high 3 cycles -> command held stable for 4 cycles; rsp_valid at accept+6 (READ_LATENCY=1).
//  - LW at 0x002, and size=11 -> rsp_err=1 one cycle after accept, avm_read/write never asserted.
//  - Back-to-back SW 0x12345678 to 0x020, then LW from 0x020 -> rsp_rdata=0x12345678. Sweep READ_LATENCY 1..4.

Source files
------------

// File: rtl/avalon_lsu_pkg.sv
// Shared encodings for the load/store-unit Avalon-MM master: access sizes, FSM states,
// read-latency bounds and the latched request record.
package avalon_lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int RL_MIN   = 1;
    localparam int RL_MAX   = 4;
    localparam int RL_CNT_W = $clog2(RL_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_RDWAIT,
        S_RESP
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } req_t;
endpackage

// File: rtl/avalon_lsu_align.sv
// Lane logic: byteenables, store-data replication, load lane extract with sign/zero
// extension, and the misaligned/illegal-size flag.
module avalon_lsu_align
    import avalon_lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    // Addressed byte/half moved down to bit 0; only the low half is ever consumed.
    logic [15:0] lane;
    assign lane = 16'(rdata_i >> {off_i, 3'b000});

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        err_o   = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{lane[7] & ~uns_i}}, lane[7:0]};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{lane[15] & ~uns_i}}, lane[15:0]};
                err_o   = off_i[0];
            end
            SZ_WORD: begin
                be_o  = 4'b1111;
                err_o = |off_i;
            end
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/avalon_lsu_master.sv
// Avalon-MM master for the core's load/store unit: one request at a time, waitrequest
// stalls, fixed slave read latency, single-cycle response pulse.
module avalon_lsu_master
    import avalon_lsu_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-3:0] avm_address_o,
    output logic [3:0]        avm_byteenable_o,
    output logic              avm_chipselect_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [31:0]       avm_writedata_o,
    input  logic [31:0]       avm_readdata_i,
    input  logic              avm_waitrequest_i
);
    state_e              state_q;
    req_t                req_q, req_cur;
    logic [RL_CNT_W-1:0] cnt_q;
    logic                ready_q, rsp_valid_q, rsp_err_q;
    logic [31:0]         rsp_rdata_q, wdata_q;
    logic [ADDR_W-3:0]   addr_q;
    logic [3:0]          be_q;
    logic                cs_q, rd_q, wr_q;
    logic [3:0]          al_be;
    logic [31:0]         al_wdata, al_rdata;
    logic                al_err;

    // In IDLE the lane logic sees the incoming request; afterwards the latched one,
    // so the load extract uses the accepted offset/size.
    always_comb begin
        req_cur = req_q;
        if (state_q == S_IDLE) begin
            req_cur = '{we: req_we_i, size: req_size_i, uns: req_unsigned_i,
                        off: req_addr_i[1:0], wdata: req_wdata_i};
        end
    end

    avalon_lsu_align u_align (
        .off_i   (req_cur.off),
        .size_i  (req_cur.size),
        .uns_i   (req_cur.uns),
        .wdata_i (req_cur.wdata),
        .rdata_i (avm_readdata_i),
        .be_o    (al_be),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata),
        .err_o   (al_err)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        req_q   <= req_cur;
                        ready_q <= 1'b0;
                        if (al_err) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= S_CMD;
                            addr_q  <= req_addr_i[ADDR_W-1:2];
                            be_q    <= al_be;
                            wdata_q <= al_wdata;
                            cs_q    <= 1'b1;
                            rd_q    <= ~req_we_i;
                            wr_q    <= req_we_i;
                        end
                    end
                end
                S_CMD: begin
                    if (!avm_waitrequest_i) begin
                        cs_q <= 1'b0;
                        rd_q <= 1'b0;
                        wr_q <= 1'b0;
                        if (req_q.we) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= S_RDWAIT;
                            cnt_q   <= RL_CNT_W'(READ_LATENCY - 1);
                        end
                    end
                end
                S_RDWAIT: begin
                    // Counter hits zero in the cycle the slave drives its data.
                    if (cnt_q == '0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= al_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o      = ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_err_o        = rsp_err_q;
    assign rsp_rdata_o      = rsp_rdata_q;
    assign avm_address_o    = addr_q;
    assign avm_byteenable_o = be_q;
    assign avm_writedata_o  = wdata_q;
    assign avm_chipselect_o = cs_q;
    assign avm_read_o       = rd_q;
    assign avm_write_o      = wr_q;
endmodule
